// File: rtl/spi_imu_serf_param_pkg.sv
// Shared types and register-map constants for the parametrised SPI inertial-sensor serf.
package spi_imu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [6:0] WHO_AM_I_ADDR = 7'h0F;
  localparam logic [6:0] CTRL_INT_ADDR = 7'h0D;
  localparam logic [6:0] CTRL_ODR_ADDR = 7'h11;
  localparam logic [6:0] STATUS_ADDR   = 7'h1E;
  localparam logic [7:0] WR_RESP       = 8'hA5;

  // Output data rate period in system clocks for a given ODR code.
  function automatic int odr_period(input int base, input logic [3:0] odr);
    return base * int'({28'd0, odr});
  endfunction

endpackage

// File: rtl/spi_imu_serf_param_if.sv
// SPI pins plus the data-ready interrupt between the inertial-interface monarch and the sensor serf.
interface spi_imu_serf_param_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, SCLK, MOSI, input MISO, INT);
  modport slave  (input SS_n, SCLK, MOSI, output MISO, INT);
endinterface

// File: rtl/spi_imu_serf_param_shft.sv
// Pin oversampling, SCLK edge detect and byte-level shift registers for the SPI serf (mode 0).
module spi_imu_shft (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic       ld_tx,
  input  logic [7:0] tx_byte,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso_bit
);

  // [1:0] is the synchronizer, [2] the delayed copy used for edge detection.
  // SS_n resets to "selected" so a frame already in flight at reset is never
  // mistaken for a new one; the master has to raise SS_n to re-frame.
  logic [2:0] ss_sync;
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] tx_pend;
  logic       ss_s;
  logic       sclk_rise;
  logic       sclk_fall;

  assign ss_s      = ss_sync[1];
  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign miso_bit  = tx_sr[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      bit_cnt   <= '0;
      rx_byte   <= '0;
      tx_sr     <= '0;
      tx_pend   <= '0;
      byte_done <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], ss_n_in};
      sclk_sync <= {sclk_sync[1:0], sclk_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
      byte_done <= 1'b0;

      if (ss_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_byte   <= {rx_byte[6:0], mosi_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end

      // The fall that closes a byte loads the next byte instead of shifting,
      // so its MSB is on MISO before the following rising edge.
      if (ss_fall) begin
        tx_sr   <= '0;
        tx_pend <= '0;
      end else begin
        if (ld_tx) tx_pend <= tx_byte;
        if (!ss_s && sclk_fall) begin
          tx_sr <= (bit_cnt == 3'd0) ? tx_pend : {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_imu_serf_param.sv
// SPI serf model of a multi-axis inertial sensor: register file, ODR engine, coherent snapshot, burst R/W.
// Build option SPI_IMU_OVERRUN_EN turns 7'h1E into a read-to-clear overrun/deferral status register.
//
// state | meaning
// IDLE  | deselected, waiting for SS_n fall
// CMD   | shifting in {RWn, addr[6:0]}
// DATA  | burst data bytes, address auto-increments
module spi_imu_serf_param
  import spi_imu_pkg::*;
#(
  parameter int         NUM_CH       = 6,
  parameter int         DATA_W       = 16,
  parameter logic [6:0] DATA_BASE    = 7'h22,
  parameter logic [7:0] WHO_AM_I     = 8'h6A,
  parameter int         ODR_BASE     = 4096,
  parameter logic [6:0] INT_CLR_ADDR = 7'h22
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_imu_serf_param_if.slave      bus,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in
);

  if (DATA_W != 16 || NUM_CH < 1 || NUM_CH > 8) begin : g_param_chk
    $error("spi_imu_serf_param: DATA_W must be 16 and NUM_CH in 1..8");
  end

  localparam int CNT_W = $clog2(ODR_BASE * 15 + 1);

  state_t                   state;
  logic                     rwn;
  logic [6:0]               ptr;
  logic                     ld_req;
  logic                     ld_tx;
  logic [7:0]               tx_byte;
  logic [7:0]               regs [128];
  logic [CNT_W-1:0]         odr_cnt;
  logic [CNT_W-1:0]         period_m1;
  logic [NUM_CH*DATA_W-1:0] snapshot;
  logic                     int_q;
  logic                     defer_q;
  logic [7:0]               rd_data;
  logic                     wr_ok;
  logic                     odr_en;
  logic                     tick;
  logic                     burst_rd;
  logic                     snap_now;
  logic                     int_clr;
  logic                     st_clr;
  logic                     ss_fall;
  logic                     ss_rise;
  logic                     byte_done;
  logic [7:0]               rx_byte;
  logic                     miso_bit;
`ifdef SPI_IMU_OVERRUN_EN
  logic                     ovr_q;
  logic                     dfr_q;
`endif

  spi_imu_shft u_shft (
    .clk       (clk),
    .rst       (rst),
    .ss_n_in   (bus.SS_n),
    .sclk_in   (bus.SCLK),
    .mosi_in   (bus.MOSI),
    .ld_tx     (ld_tx),
    .tx_byte   (tx_byte),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .miso_bit  (miso_bit)
  );

  assign bus.MISO = bus.SS_n ? 1'bz : miso_bit;
  assign bus.INT  = int_q;

  assign odr_en    = regs[CTRL_INT_ADDR][1] && (regs[CTRL_ODR_ADDR][7:4] != 4'd0);
  assign period_m1 = CNT_W'(odr_period(ODR_BASE, regs[CTRL_ODR_ADDR][7:4]) - 1);
  assign tick      = odr_en && (odr_cnt >= period_m1);
  assign burst_rd  = (state == DATA) && rwn;
  assign snap_now  = (tick || defer_q) && !burst_rd;
  assign int_clr   = (state == CMD) && byte_done && rx_byte[7] && (rx_byte[6:0] == INT_CLR_ADDR);
  assign st_clr    = ld_req && rwn && (ptr == STATUS_ADDR);

  always_comb begin
    rd_data = regs[ptr];
    wr_ok   = (ptr != WHO_AM_I_ADDR);
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      if (int'(ptr) == int'(DATA_BASE) + i) begin
        rd_data = snapshot[8*i +: 8];
        wr_ok   = 1'b0;
      end
    end
    if (ptr == WHO_AM_I_ADDR) rd_data = WHO_AM_I;
`ifdef SPI_IMU_OVERRUN_EN
    if (ptr == STATUS_ADDR) begin
      rd_data = {6'd0, dfr_q, ovr_q};
      wr_ok   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rwn     <= 1'b0;
      ptr     <= '0;
      ld_req  <= 1'b0;
      ld_tx   <= 1'b0;
      tx_byte <= '0;
      for (int a = 0; a < 128; a++) regs[a] <= 8'h00;
    end else begin
      ld_req <= 1'b0;
      ld_tx  <= ld_req;
      if (ld_req) tx_byte <= rwn ? rd_data : WR_RESP;

      case (state)
        IDLE: if (ss_fall) state <= CMD;
        CMD: begin
          if (byte_done) begin
            rwn    <= rx_byte[7];
            ptr    <= rx_byte[6:0];
            ld_req <= 1'b1;
            state  <= DATA;
          end
        end
        DATA: begin
          if (byte_done) begin
            if (!rwn && wr_ok) regs[ptr] <= rx_byte;
            ptr    <= ptr + 7'd1;
            ld_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (ss_rise) begin
        state  <= IDLE;
        ld_req <= 1'b0;
      end
    end
  end

  // A tick landing inside a read burst is held until the burst ends so the
  // master never sees a mix of old and new channel bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      odr_cnt  <= '0;
      snapshot <= '0;
      int_q    <= 1'b0;
      defer_q  <= 1'b0;
    end else begin
      if (!odr_en || tick) odr_cnt <= '0;
      else                 odr_cnt <= odr_cnt + CNT_W'(1);

      if (snap_now) snapshot <= smpl_in;

      if (tick && burst_rd) defer_q <= 1'b1;
      else if (snap_now)    defer_q <= 1'b0;

      if (snap_now)     int_q <= 1'b1;
      else if (int_clr) int_q <= 1'b0;
    end
  end

`ifdef SPI_IMU_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
      dfr_q <= 1'b0;
    end else begin
      if (tick && int_q) ovr_q <= 1'b1;
      else if (st_clr)   ovr_q <= 1'b0;

      if (tick && burst_rd) dfr_q <= 1'b1;
      else if (st_clr)      dfr_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_imu_serf_param.sv
// Randomised scoreboard bench for spi_imu_serf_param: SPI driver, MISO byte monitor, register-map model.
module tb_spi_imu_serf_param;
  import spi_imu_pkg::*;

  localparam int         NUM_CH = 6;
  localparam logic [6:0] DBASE  = 7'h22;
  localparam int         HALF   = 80;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH*16-1:0] smpl_in;

  spi_imu_serf_param_if bus ();

  spi_imu_serf_param #(
    .NUM_CH(NUM_CH), .DATA_W(16), .DATA_BASE(DBASE), .WHO_AM_I(8'h6A),
    .ODR_BASE(4096), .INT_CLR_ADDR(7'h22)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .smpl_in(smpl_in)
  );

  always #5 clk = ~clk;

  int                   n_chk  = 0;
  int                   n_fail = 0;
  logic [7:0]           exp_q[$];
  logic [7:0]           mreg[128];
  logic [NUM_CH*16-1:0] msnap;
  logic [7:0]           mstat;
  logic [7:0]           wbuf[16];
  int                   chg_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    int off;
    off = int'(a) - int'(DBASE);
    if (a == 7'h0F) return 8'h6A;
    if (off >= 0 && off < 2 * NUM_CH) return msnap[8*off +: 8];
`ifdef SPI_IMU_OVERRUN_EN
    if (a == 7'h1E) return mstat;
`endif
    return mreg[a];
  endfunction

  function automatic bit model_wr_ok(input logic [6:0] a);
    int off;
    off = int'(a) - int'(DBASE);
    if (a == 7'h0F) return 1'b0;
    if (off >= 0 && off < 2 * NUM_CH) return 1'b0;
`ifdef SPI_IMU_OVERRUN_EN
    if (a == 7'h1E) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic spi_byte(input logic [7:0] tx, input int nbits);
    for (int b = 7; b >= 8 - nbits; b--) begin
      bus.MOSI = tx[b];
      #(HALF);
      bus.SCLK = 1'b1;
      #(HALF);
      bus.SCLK = 1'b0;
    end
  endtask

  // One framed transaction; abort_bits > 0 truncates the last write byte.
  task automatic frame(input bit rd, input logic [6:0] addr, input int n, input int abort_bits);
    logic [6:0] a;
    a = addr;
    @(negedge clk);
    bus.SS_n = 1'b0;
    #(HALF);
    exp_q.push_back(8'h00);
    spi_byte({rd, addr}, 8);
    for (int k = 0; k < n; k++) begin
      if (k == chg_at) smpl_in = {$urandom, $urandom, $urandom};
      if (rd) begin
        exp_q.push_back(model_rd(a));
        if (a == 7'h1E) mstat = 8'h00;
        spi_byte(8'h00, 8);
      end else if (abort_bits > 0 && k == n - 1) begin
        spi_byte(wbuf[k], abort_bits);
      end else begin
        exp_q.push_back(WR_RESP);
        spi_byte(wbuf[k], 8);
        if (model_wr_ok(a)) mreg[a] = wbuf[k];
      end
      a = a + 7'd1;
    end
    #(HALF);
    bus.SS_n = 1'b1;
    #(2 * HALF);
  endtask

  task automatic wr1(input logic [6:0] addr, input logic [7:0] d);
    wbuf[0] = d;
    frame(1'b0, addr, 1, 0);
  endtask

  task automatic wait_int(input int limit, output int cyc);
    cyc = 0;
    while (bus.INT !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Monitor: assembles MISO bits on each SCLK rise and scores every full byte.
  initial begin
    int         bits;
    logic [7:0] sr;
    logic [7:0] e;
    bits = 0;
    sr   = '0;
    forever begin
      @(posedge bus.SCLK or posedge bus.SS_n);
      if (bus.SS_n === 1'b1) begin
        bits = 0;
      end else begin
        sr = {sr[6:0], bus.MISO};
        bits++;
        if (bits == 8) begin
          bits = 0;
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(sr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("miso_byte", 32'(sr), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    smpl_in  = {$urandom, $urandom, $urandom};
    for (int a = 0; a < 128; a++) mreg[a] = 8'h00;
    msnap = '0;
    mstat = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("int_reset", 32'(bus.INT), 32'd0);

    frame(1'b1, 7'h0F, 1, 0);
    wr1(7'h0D, 8'h02);
    frame(1'b1, 7'h0D, 1, 0);

    // Enable ODR x1 and time the first interrupt from the enabling frame.
    smpl_in[15:0] = 16'h1234;
    wr1(7'h11, 8'h10);
    check("int_before_tick", 32'(bus.INT), 32'd0);
    wait_int(4300, cyc);
    check("int_rise_window", 32'(cyc >= 4030 && cyc <= 4100), 32'd1);
    msnap = smpl_in;
    frame(1'b1, 7'h22, 1, 0);
    check("int_clear", 32'(bus.INT), 32'd0);
    wr1(7'h0D, 8'h00);
    repeat (5000) @(negedge clk);
    check("int_disabled", 32'(bus.INT), 32'd0);

    // Coherent burst: sample change mid-burst must not be visible.
    chg_at = 4;
    frame(1'b1, 7'h22, 2 * NUM_CH, 0);
    chg_at = -1;

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    frame(1'b0, 7'h7F, 2, 0);
    frame(1'b1, 7'h7F, 2, 0);

    wr1(7'h05, 8'h5A);
    wbuf[0] = 8'hFF;
    frame(1'b0, 7'h05, 1, 5);
    frame(1'b1, 7'h05, 1, 0);
    wr1(7'h0F, 8'h00);
    frame(1'b1, 7'h0F, 1, 0);

    // Two ticks with INT left pending.
    wr1(7'h0D, 8'h02);
    wait_int(4300, cyc);
    check("int_first_tick", 32'(bus.INT), 32'd1);
    repeat (4150) @(negedge clk);
    wr1(7'h0D, 8'h00);
    check("int_held", 32'(bus.INT), 32'd1);
    msnap = smpl_in;
`ifdef SPI_IMU_OVERRUN_EN
    mstat = 8'h01;
    frame(1'b1, 7'h1E, 1, 0);
    frame(1'b1, 7'h1E, 1, 0);
`endif
    frame(1'b1, 7'h24, 4, 0);

    // Synchronous reset in the middle of a write data byte.
    @(negedge clk);
    bus.SS_n = 1'b0;
    #(HALF);
    exp_q.push_back(8'h00);
    spi_byte({1'b0, 7'h05}, 8);
    spi_byte(8'hC3, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("int_after_rst", 32'(bus.INT), 32'd0);
    #(HALF);
    bus.SS_n = 1'b1;
    #(2 * HALF);
    for (int a = 0; a < 128; a++) mreg[a] = 8'h00;
    msnap = '0;
    mstat = 8'h00;
    frame(1'b1, 7'h0F, 1, 0);
    frame(1'b1, 7'h05, 1, 0);

    // Random bursts; ODR code forced to 0 so the snapshot stays static.
    for (int t = 0; t < 40; t++) begin
      bit         rd;
      logic [6:0] addr;
      int         n;
      rd   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 127));
      n    = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        wbuf[k] = 8'($urandom);
        if (7'(addr + 7'(k)) == 7'h11) wbuf[k] = wbuf[k] & 8'h0F;
      end
      frame(rd, addr, n, 0);
    end

    repeat (20) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
